// File: rtl/cc_pkg.sv
// cc_seq shared types: FSM states, opt bit positions
// and the default result width.
package cc_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_NORM,
    S_EQU,
    S_OUT
  } state_t;

  localparam int OPT_SIGNED = 0;
  localparam int OPT_DESC   = 1;
  localparam int OPT_MAVG   = 2;

  function automatic int cc_out_w(input int w);
    return 2 * w + 2;
  endfunction
endpackage

// File: rtl/cc_sort_insert.sv
// Sorted register buffer; one parallel compare/shift
// insertion per cycle, new value placed after equals.
module cc_sort_insert
  import cc_pkg::*;
#(
  parameter int N  = 6,
  parameter int EW = 5
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 ins,
  input  logic signed [EW-1:0] din,
  input  logic                 desc,
  output logic [N*EW-1:0]      sorted
);
  logic signed [EW-1:0] r_s [N];
  logic [N-1:0]         r_v;
  logic [N-1:0]         w_pre;
  logic [N-1:0]         w_bpre;
  logic signed [EW-1:0] w_below [N];

  // Valid entries form a prefix, so w_pre is a prefix too.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_pre[i] = r_v[i] &&
        (desc ? (r_s[i] >= din) : (r_s[i] <= din));
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_slot
    if (i == 0) begin : g_lo
      assign w_bpre[i]  = 1'b1;
      assign w_below[i] = din;
    end else begin : g_hi
      assign w_bpre[i]  = w_pre[i-1];
      assign w_below[i] = r_s[i-1];
    end
    assign sorted[i*EW +: EW] = r_s[i];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_v <= '0;
      for (int i = 0; i < N; i++) r_s[i] <= '0;
    end else if (ins) begin
      r_v <= {r_v[N-2:0], 1'b1};
      for (int i = 0; i < N; i++) begin
        if (!w_pre[i])
          r_s[i] <= w_bpre[i] ? din : w_below[i];
      end
    end
  end
endmodule

// File: rtl/cc_seq.sv
// Serial frame sorter: insert N samples, normalise the
// sorted buffer, evaluate eq0/eq1, pulse one result.
module cc_seq
  import cc_pkg::*;
#(
  parameter int N     = 6,
  parameter int W     = 4,
  parameter int OUT_W = cc_out_w(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic [2:0]       opt,
  input  logic             equ,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_n
);
  localparam int EW = W + 1;
  localparam int IW = OUT_W + 2;
  localparam int AW = W + 4;
  localparam int CW = $clog2(N + 1);
  localparam logic signed [AW-1:0] A3 = 3;
  localparam logic signed [IW-1:0] I3 = 3;

  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, r_j;
  logic [2:0] r_opt;
  logic r_equ;
  logic signed [EW-1:0] r_norm [N];
  logic signed [OUT_W-1:0] r_out;

  logic w_idle, w_acc, w_sgn, w_desc, w_mavg;
  logic signed [EW-1:0] w_din;
  logic [N*EW-1:0] w_sorted;
  logic signed [EW-1:0] w_s [N];
  logic signed [EW-1:0] w_prev, w_cur, w_nm;
  logic signed [AW-1:0] w_sum, w_avg;
  logic signed [IW-1:0] w_a, w_b, w_c, w_n0, w_n1;
  logic signed [IW-1:0] w_e0, w_d, w_e1, w_eq;

  assign w_idle    = (r_state == S_IDLE);
  assign in_ready  = w_idle || (r_state == S_LOAD);
  assign w_acc     = in_valid && in_ready;
  assign out_valid = (r_state == S_OUT);
  assign out_n     = out_valid ? r_out : '0;

  // First sample of a frame uses live opt; later ones the latch.
  assign w_sgn  = w_idle ? opt[OPT_SIGNED] : r_opt[OPT_SIGNED];
  assign w_desc = w_idle ? opt[OPT_DESC] : r_opt[OPT_DESC];
  assign w_mavg = r_opt[OPT_MAVG];
  assign w_din  = {w_sgn & in_data[W-1], in_data};

  cc_sort_insert #(.N(N), .EW(EW)) u_sort (
    .clk    (clk),
    .clr    (rst || out_valid),
    .ins    (w_acc),
    .din    (w_din),
    .desc   (w_desc),
    .sorted (w_sorted)
  );

  always_comb begin
    for (int i = 0; i < N; i++)
      w_s[i] = w_sorted[i*EW +: EW];
  end

  always_comb begin
    w_prev = w_s[0];
    w_cur  = w_s[0];
    for (int i = 1; i < N - 1; i++)
      if (r_j == CW'(i + 1)) w_prev = r_norm[i];
    for (int i = 1; i < N; i++)
      if (r_j == CW'(i)) w_cur = w_s[i];
  end

  assign w_sum = (AW'(w_prev) <<< 1) + AW'(w_cur);
  assign w_avg = w_sum / A3;
  assign w_nm  = w_mavg ? w_avg[EW-1:0] : (w_cur - w_s[0]);

  assign w_a  = IW'(r_norm[N-3]);
  assign w_b  = IW'(r_norm[N-2]);
  assign w_c  = IW'(r_norm[N-1]);
  assign w_n0 = IW'(r_norm[0]);
  assign w_n1 = IW'(r_norm[1]);
  assign w_e0 = ((w_a + (w_b <<< 2)) * w_c) / I3;
  assign w_d  = (w_n0 - w_n1) * w_c;
  assign w_e1 = w_d[IW-1] ? -w_d : w_d;
  assign w_eq = r_equ ? w_e1 : w_e0;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_acc) w_next = S_LOAD;
      S_LOAD:
        if (w_acc && r_cnt == CW'(N - 1))
          w_next = S_NORM;
      S_NORM:
        if (r_j == CW'(N - 1)) w_next = S_EQU;
      S_EQU:  w_next = S_OUT;
      S_OUT:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_j     <= '0;
      r_opt   <= '0;
      r_equ   <= 1'b0;
      r_out   <= '0;
      for (int i = 0; i < N; i++) r_norm[i] <= '0;
    end else begin
      r_state <= w_next;
      r_j <= (r_state == S_NORM) ? r_j + 1'b1 : CW'(1);
      if (w_acc) begin
        r_cnt <= w_idle ? CW'(1) : r_cnt + 1'b1;
        if (w_idle) begin
          r_opt <= opt;
          r_equ <= equ;
        end
      end
      if (r_state == S_NORM) begin
        if (r_j == CW'(1))
          r_norm[0] <= w_mavg ? w_s[0] : '0;
        for (int i = 1; i < N; i++)
          if (r_j == CW'(i)) r_norm[i] <= w_nm;
      end
      if (r_state == S_EQU)
        r_out <= w_eq[OUT_W-1:0];
    end
  end
endmodule
